bexkat1_writeback: RTL and testbench
====================================

# bexkat1_writeback

Final (writeback) stage of the bexkat1 pipeline, directly downstream of the memory stage. Holds the 16×32 general register file and the two banked stack pointers, and commits the memory stage's registered results. Provides bypassed read ports to decode and a one-cycle PC redirect pulse to fetch. Also keeps a sticky halt flag and a 32-bit retired-instruction counter.

## Interface
- No parameters.
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  memory stage output holds a real instruction (not a bubble)
- stall_i  in  1  memory stage stalled; its outputs are being held and must not commit
- result_i  in  32  value for GPR write and for PC redirect
- reg_write_i  in  2  GPR write mode: 00 none, 01 low half, 10 high half, 11 full word
- reg_write_addr_i  in  4  destination GPR
- sp_write_i  in  2  SP write mode, same encoding as reg_write_i
- sp_data_i  in  32  new stack pointer value
- pc_i  in  32  redirect target for exceptions
- pc_set_i  in  1  instruction redirects PC to result_i
- exc_i  in  1  exception commit; redirect to pc_i
- halt_i  in  1  halt instruction commits
- bank_i  in  4  mode bank; bit 0 selects supervisor SP (1) or user SP (0)
- rd_addr1_i, rd_addr2_i  in  4 each  decode read addresses
- rd_data1_o, rd_data2_o  out  32 each  bypassed GPR read data
- sp_o  out  32  bypassed SP of bank selected by bank_i[0]
- pc_o  out  32  redirect target to fetch
- pc_set_o  out  1  one-cycle redirect pulse
- halted_o  out  1  sticky halt flag
- retired_o  out  32  committed-instruction count

## Operation
- commit = valid_i & ~stall_i & ~halted_o. Without commit, no architectural state changes.
- GPR write on commit:
  - 11: reg[a] = result_i
  - 01: reg[a][15:0] = result_i[15:0], upper bits kept
  - 10: reg[a][31:16] = result_i[15:0], lower bits kept
- SP write on commit uses the same mode encoding with sp_data_i. The target is ssp when bank_i[0]=1, otherwise usp.
- GPR and SP writes in the same commit are both applied.
- Redirect on commit:
  - exc_i=1 takes priority: pc_o <= pc_i.
  - else pc_set_i=1: pc_o <= result_i.
  - pc_set_o <= 1 for exactly one cycle after that commit, then 0. pc_o holds its value otherwise.
- Halt: a commit with halt_i=1 still performs its writes and count, then sets halted_o. halted_o stays 1 until reset, and blocks all further commits.
- retired_o increments by 1 per commit and wraps 0xFFFFFFFF to 0.
- Reads are combinational with bypass:
  - if a commit writes GPR rd_addrN_i this cycle, rd_dataN_o returns the merged post-write value.
  - sp_o bypasses the same way when the SP write hits the bank it reads.

## Timing
- Reset (synchronous, on clock edge while rst_i=1), clears:
  - all 16 GPRs, usp, ssp: 0
  - pc_o = 0, pc_set_o = 0, halted_o = 0, retired_o = 0
- rst_i overrides a simultaneous commit. Reset mid-operation discards the in-flight commit.
- Write latency: state visible in registers after the commit edge, visible on read ports in the commit cycle itself via bypass.
- Redirect latency: pc_set_o/pc_o valid the cycle after the commit edge.
- stall_i held for N cycles with a held write: exactly one write and one count, on the first cycle stall_i is low.
- Back-to-back commits to the same register: each cycle's bypass reflects that cycle's write on top of the prior value.

## Test plan
- Reset, then read r0–r15 and sp_o → all 0; pc_set_o=0; halted_o=0; retired_o=0.
- Commit reg_write=11 addr 3 result 0x12345678, then reg_write=01 addr 3 result 0xAAAABEEF → r3 = 0x1234BEEF. Bypass shows 0x12345678 during the first cycle; retired_o=2.
- Hold valid with stall_i=1 for 3 cycles, then release, with write 0xDEADBEEF to r5 → r5 written once; retired_o increments by exactly 1.
- Commit with bank_i[0]=1, sp_write=11, sp_data 0x0000FFF0, plus exc_i=1, pc_i 0x100 → ssp=0xFFF0 and usp unchanged; next cycle pc_set_o=1, pc_o=0x100; following cycle pc_set_o=0.
- Commit halt_i=1 with a write of 7 to r1, then further valid writes to r1 → r1=7; halted_o=1; retired_o frozen.
- Preload retired_o to 0xFFFFFFFF via repeated commits, commit once more → wraps to 0. Assert rst_i during a commit → the write is lost and all outputs return to reset values.

Source files
------------

// File: rtl/bexkat1_writeback_if.sv
// Memory-stage-to-writeback bundle plus decode read ports and fetch redirect.
interface bexkat1_writeback_if;
  // Commit payload from the memory stage
  logic        valid_i;
  logic        stall_i;
  logic [31:0] result_i;
  logic [1:0]  reg_write_i;
  logic [3:0]  reg_write_addr_i;
  logic [1:0]  sp_write_i;
  logic [31:0] sp_data_i;
  logic [31:0] pc_i;
  logic        pc_set_i;
  logic        exc_i;
  logic        halt_i;
  logic [3:0]  bank_i;

  // Decode read ports
  logic [3:0]  rd_addr1_i;
  logic [3:0]  rd_addr2_i;
  logic [31:0] rd_data1_o;
  logic [31:0] rd_data2_o;
  logic [31:0] sp_o;

  // Fetch redirect and status
  logic [31:0] pc_o;
  logic        pc_set_o;
  logic        halted_o;
  logic [31:0] retired_o;

  // Upstream side: memory stage, decode and fetch
  modport master (
    output valid_i, stall_i, result_i, reg_write_i, reg_write_addr_i,
           sp_write_i, sp_data_i, pc_i, pc_set_i, exc_i, halt_i, bank_i,
           rd_addr1_i, rd_addr2_i,
    input  rd_data1_o, rd_data2_o, sp_o, pc_o, pc_set_o, halted_o, retired_o
  );

  // Writeback stage side
  modport slave (
    input  valid_i, stall_i, result_i, reg_write_i, reg_write_addr_i,
           sp_write_i, sp_data_i, pc_i, pc_set_i, exc_i, halt_i, bank_i,
           rd_addr1_i, rd_addr2_i,
    output rd_data1_o, rd_data2_o, sp_o, pc_o, pc_set_o, halted_o, retired_o
  );
endinterface

// File: rtl/bexkat1_writeback.sv
// bexkat1 writeback stage: register file, banked SPs, PC redirect, halt and retire count.
module bexkat1_writeback (
  input logic                clk_i,
  input logic                rst_i,
  bexkat1_writeback_if.slave wb
);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 16;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] usp_q, usp_d;
  logic [DATA_W-1:0] ssp_q, ssp_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] retired_q, retired_d;
  logic              pc_set_q, pc_set_d;
  logic              halted_q, halted_d;

  logic              commit_c;
  logic              reg_we_c;
  logic              sp_we_c;
  logic [DATA_W-1:0] reg_wdata_c;
  logic [DATA_W-1:0] sp_cur_c;
  logic [DATA_W-1:0] sp_wdata_c;

  // Only the low bank bit selects the stack pointer
  logic unused_bank_c;
  assign unused_bank_c = ^wb.bank_i[3:1];

  // Half/full word merge: 01 writes low half, 10 moves new[15:0] into the high half
  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [1:0]        mode
  );
    logic [DATA_W-1:0] res;
    case (mode)
      2'b11:   res = new_val;
      2'b01:   res = {old_val[31:16], new_val[15:0]};
      2'b10:   res = {new_val[15:0], old_val[15:0]};
      default: res = old_val;
    endcase
    return res;
  endfunction

  // Commit qualification and merged write values (shared by state update and bypass)
  always_comb begin
    commit_c    = wb.valid_i & ~wb.stall_i & ~halted_q;
    reg_we_c    = commit_c & (wb.reg_write_i != 2'b00);
    sp_we_c     = commit_c & (wb.sp_write_i != 2'b00);
    reg_wdata_c = merge_word(regs_q[wb.reg_write_addr_i], wb.result_i, wb.reg_write_i);
    sp_cur_c    = wb.bank_i[0] ? ssp_q : usp_q;
    sp_wdata_c  = merge_word(sp_cur_c, wb.sp_data_i, wb.sp_write_i);
  end

  // Next-state for SPs, redirect, halt and retire count
  always_comb begin
    usp_d     = usp_q;
    ssp_d     = ssp_q;
    pc_d      = pc_q;
    pc_set_d  = 1'b0;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (commit_c) begin
      retired_d = retired_q + DATA_W'(1);
      if (sp_we_c) begin
        if (wb.bank_i[0]) ssp_d = sp_wdata_c;
        else              usp_d = sp_wdata_c;
      end
      if (wb.exc_i) begin
        pc_d     = wb.pc_i;
        pc_set_d = 1'b1;
      end else if (wb.pc_set_i) begin
        pc_d     = wb.result_i;
        pc_set_d = 1'b1;
      end
      if (wb.halt_i) halted_d = 1'b1;
    end
  end

  // General register file
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (reg_we_c) begin
      regs_q[wb.reg_write_addr_i] <= reg_wdata_c;
    end
  end

  // Stack pointers, redirect, halt flag and retire counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      usp_q     <= '0;
      ssp_q     <= '0;
      pc_q      <= '0;
      pc_set_q  <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      usp_q     <= usp_d;
      ssp_q     <= ssp_d;
      pc_q      <= pc_d;
      pc_set_q  <= pc_set_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // Bypassed read ports: a same-cycle commit to the read target returns the merged value
  always_comb begin
    wb.rd_data1_o = (reg_we_c && (wb.reg_write_addr_i == wb.rd_addr1_i))
                    ? reg_wdata_c : regs_q[wb.rd_addr1_i];
    wb.rd_data2_o = (reg_we_c && (wb.reg_write_addr_i == wb.rd_addr2_i))
                    ? reg_wdata_c : regs_q[wb.rd_addr2_i];
    // Read and write bank are both bank_i[0], so any SP write hits the read
    wb.sp_o       = sp_we_c ? sp_wdata_c : sp_cur_c;
  end

  assign wb.pc_o      = pc_q;
  assign wb.pc_set_o  = pc_set_q;
  assign wb.halted_o  = halted_q;
  assign wb.retired_o = retired_q;
endmodule

// File: tb/tb_bexkat1_writeback.sv
// Scenario bench for bexkat1_writeback with a register read-back scoreboard.
module tb_bexkat1_writeback;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   exp_ret;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  bexkat1_writeback_if wb_if();

  bexkat1_writeback dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic idle;
    wb_if.valid_i          = 1'b0;
    wb_if.stall_i          = 1'b0;
    wb_if.result_i         = '0;
    wb_if.reg_write_i      = 2'b00;
    wb_if.reg_write_addr_i = '0;
    wb_if.sp_write_i       = 2'b00;
    wb_if.sp_data_i        = '0;
    wb_if.pc_i             = '0;
    wb_if.pc_set_i         = 1'b0;
    wb_if.exc_i            = 1'b0;
    wb_if.halt_i           = 1'b0;
    wb_if.bank_i           = '0;
    wb_if.rd_addr1_i       = '0;
    wb_if.rd_addr2_i       = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wb_if.rd_addr1_i = 4'(i);
      wb_if.rd_addr2_i = 4'(15 - i);
      #1;
      n_checks++;
      if (wb_if.rd_data1_o !== 32'h0) $display("FAIL reset_rd1 r%0d got %h want 0", i, wb_if.rd_data1_o);
      else n_pass++;
      n_checks++;
      if (wb_if.rd_data2_o !== 32'h0) $display("FAIL reset_rd2 r%0d got %h want 0", 15 - i, wb_if.rd_data2_o);
      else n_pass++;
    end
    for (int b = 0; b < 2; b++) begin
      wb_if.bank_i = 4'(b);
      #1;
      n_checks++;
      if (wb_if.sp_o !== 32'h0) $display("FAIL reset_sp bank%0d got %h want 0", b, wb_if.sp_o);
      else n_pass++;
    end
    n_checks++;
    if (wb_if.pc_set_o !== 1'b0) $display("FAIL reset_pc_set got %b want 0", wb_if.pc_set_o);
    else n_pass++;
    n_checks++;
    if (wb_if.pc_o !== 32'h0) $display("FAIL reset_pc got %h want 0", wb_if.pc_o);
    else n_pass++;
    n_checks++;
    if (wb_if.halted_o !== 1'b0) $display("FAIL reset_halted got %b want 0", wb_if.halted_o);
    else n_pass++;
    n_checks++;
    if (wb_if.retired_o !== 32'h0) $display("FAIL reset_retired got %h want 0", wb_if.retired_o);
    else n_pass++;
    exp_ret = 0;
  endtask

  task automatic test_partial_write;
    exp_t e;
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.reg_write_i = 2'b11; wb_if.reg_write_addr_i = 4'd3;
    wb_if.result_i = 32'h1234_5678; wb_if.rd_addr1_i = 4'd3; wb_if.rd_addr2_i = 4'd3;
    #1;
    n_checks++;
    if (wb_if.rd_data1_o !== 32'h1234_5678) $display("FAIL bypass_full got %h want 12345678", wb_if.rd_data1_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret++;
    @(negedge clk);
    wb_if.reg_write_i = 2'b01; wb_if.result_i = 32'hAAAA_BEEF;
    #1;
    n_checks++;
    if (wb_if.rd_data2_o !== 32'h1234_BEEF) $display("FAIL bypass_low got %h want 1234beef", wb_if.rd_data2_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret++;
    n_checks++;
    if (wb_if.retired_o !== 32'(exp_ret)) $display("FAIL retired_two got %h want %h", wb_if.retired_o, 32'(exp_ret));
    else n_pass++;
    @(negedge clk);
    wb_if.reg_write_i = 2'b10; wb_if.result_i = 32'h0000_CAFE;
    #1;
    n_checks++;
    if (wb_if.rd_data1_o !== 32'hCAFE_BEEF) $display("FAIL bypass_high got %h want cafebeef", wb_if.rd_data1_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret++;
    sb.push_back('{addr: 4'd3, val: 32'hCAFE_BEEF});
    @(negedge clk);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_if.rd_addr1_i = e.addr;
      #1;
      n_checks++;
      if (wb_if.rd_data1_o !== e.val) $display("FAIL partial_rb r%0d got %h want %h", e.addr, wb_if.rd_data1_o, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    exp_t e;
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.stall_i = 1'b1; wb_if.reg_write_i = 2'b11;
    wb_if.reg_write_addr_i = 4'd5; wb_if.result_i = 32'hDEAD_BEEF; wb_if.rd_addr1_i = 4'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (wb_if.rd_data1_o !== 32'h0) $display("FAIL stall_bypass cyc%0d got %h want 0", c, wb_if.rd_data1_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (wb_if.retired_o !== 32'(exp_ret)) $display("FAIL stall_retired cyc%0d got %h want %h", c, wb_if.retired_o, 32'(exp_ret));
      else n_pass++;
      @(negedge clk);
    end
    wb_if.stall_i = 1'b0;
    #1;
    n_checks++;
    if (wb_if.rd_data1_o !== 32'hDEAD_BEEF) $display("FAIL stall_release_bypass got %h want deadbeef", wb_if.rd_data1_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret++;
    sb.push_back('{addr: 4'd5, val: 32'hDEAD_BEEF});
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (wb_if.retired_o !== 32'(exp_ret)) $display("FAIL stall_once got %h want %h", wb_if.retired_o, 32'(exp_ret));
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_if.rd_addr2_i = e.addr;
      #1;
      n_checks++;
      if (wb_if.rd_data2_o !== e.val) $display("FAIL stall_rb r%0d got %h want %h", e.addr, wb_if.rd_data2_o, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_sp_redirect;
    exp_t e;
    // Supervisor SP write with exception; exception beats pc_set_i
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.bank_i = 4'b0001; wb_if.sp_write_i = 2'b11;
    wb_if.sp_data_i = 32'h0000_FFF0; wb_if.exc_i = 1'b1; wb_if.pc_i = 32'h0000_0100;
    wb_if.pc_set_i = 1'b1; wb_if.result_i = 32'h0000_0200;
    #1;
    n_checks++;
    if (wb_if.sp_o !== 32'h0000_FFF0) $display("FAIL ssp_bypass got %h want 0000fff0", wb_if.sp_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret++;
    n_checks++;
    if (wb_if.pc_set_o !== 1'b1) $display("FAIL exc_pc_set got %b want 1", wb_if.pc_set_o);
    else n_pass++;
    n_checks++;
    if (wb_if.pc_o !== 32'h0000_0100) $display("FAIL exc_pc got %h want 00000100", wb_if.pc_o);
    else n_pass++;
    @(negedge clk);
    idle();
    wb_if.bank_i = 4'b0001;
    #1;
    n_checks++;
    if (wb_if.sp_o !== 32'h0000_FFF0) $display("FAIL ssp_state got %h want 0000fff0", wb_if.sp_o);
    else n_pass++;
    wb_if.bank_i = 4'b1110;
    #1;
    n_checks++;
    if (wb_if.sp_o !== 32'h0) $display("FAIL usp_untouched got %h want 0", wb_if.sp_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_if.pc_set_o !== 1'b0) $display("FAIL pc_set_pulse got %b want 0", wb_if.pc_set_o);
    else n_pass++;
    n_checks++;
    if (wb_if.pc_o !== 32'h0000_0100) $display("FAIL pc_hold got %h want 00000100", wb_if.pc_o);
    else n_pass++;
    // Plain branch redirect to result_i
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.pc_set_i = 1'b1; wb_if.result_i = 32'h0000_2000;
    wb_if.pc_i = 32'h0000_0999;
    @(posedge clk); #1;
    exp_ret++;
    n_checks++;
    if (wb_if.pc_o !== 32'h0000_2000 || wb_if.pc_set_o !== 1'b1)
      $display("FAIL branch_redirect got pc %h set %b want 00002000 1", wb_if.pc_o, wb_if.pc_set_o);
    else n_pass++;
    // User SP full write together with a GPR write
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.sp_write_i = 2'b11; wb_if.sp_data_i = 32'h1111_2222;
    wb_if.reg_write_i = 2'b11; wb_if.reg_write_addr_i = 4'd4; wb_if.result_i = 32'hABCD_0000;
    @(posedge clk); #1;
    exp_ret++;
    sb.push_back('{addr: 4'd4, val: 32'hABCD_0000});
    n_checks++;
    if (wb_if.pc_set_o !== 1'b0 || wb_if.pc_o !== 32'h0000_2000)
      $display("FAIL no_redirect got pc %h set %b want 00002000 0", wb_if.pc_o, wb_if.pc_set_o);
    else n_pass++;
    // User SP high-half write
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.sp_write_i = 2'b10; wb_if.sp_data_i = 32'h5555_AAAA;
    #1;
    n_checks++;
    if (wb_if.sp_o !== 32'hAAAA_2222) $display("FAIL usp_high_bypass got %h want aaaa2222", wb_if.sp_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret++;
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (wb_if.sp_o !== 32'hAAAA_2222) $display("FAIL usp_state got %h want aaaa2222", wb_if.sp_o);
    else n_pass++;
    wb_if.bank_i = 4'b0001;
    #1;
    n_checks++;
    if (wb_if.sp_o !== 32'h0000_FFF0) $display("FAIL ssp_kept got %h want 0000fff0", wb_if.sp_o);
    else n_pass++;
    n_checks++;
    if (wb_if.retired_o !== 32'(exp_ret)) $display("FAIL sp_retired got %h want %h", wb_if.retired_o, 32'(exp_ret));
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_if.rd_addr1_i = e.addr;
      #1;
      n_checks++;
      if (wb_if.rd_data1_o !== e.val) $display("FAIL sp_gpr_rb r%0d got %h want %h", e.addr, wb_if.rd_data1_o, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.reg_write_i = 2'b11; wb_if.reg_write_addr_i = 4'd7;
    wb_if.result_i = 32'h1111_2222; wb_if.rd_addr1_i = 4'd7; wb_if.rd_addr2_i = 4'd3;
    #1;
    n_checks++;
    if (wb_if.rd_data1_o !== 32'h1111_2222) $display("FAIL b2b_first got %h want 11112222", wb_if.rd_data1_o);
    else n_pass++;
    n_checks++;
    if (wb_if.rd_data2_o !== 32'hCAFE_BEEF) $display("FAIL b2b_other got %h want cafebeef", wb_if.rd_data2_o);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    wb_if.reg_write_i = 2'b10; wb_if.result_i = 32'h0000_3333;
    #1;
    n_checks++;
    if (wb_if.rd_data1_o !== 32'h3333_2222) $display("FAIL b2b_second got %h want 33332222", wb_if.rd_data1_o);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    wb_if.reg_write_i = 2'b01; wb_if.result_i = 32'h0000_4444; wb_if.rd_addr2_i = 4'd7;
    #1;
    n_checks++;
    if (wb_if.rd_data2_o !== 32'h3333_4444) $display("FAIL b2b_third got %h want 33334444", wb_if.rd_data2_o);
    else n_pass++;
    @(posedge clk); #1;
    exp_ret += 3;
    sb.push_back('{addr: 4'd7, val: 32'h3333_4444});
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (wb_if.retired_o !== 32'(exp_ret)) $display("FAIL b2b_retired got %h want %h", wb_if.retired_o, 32'(exp_ret));
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_if.rd_addr1_i = e.addr;
      #1;
      n_checks++;
      if (wb_if.rd_data1_o !== e.val) $display("FAIL b2b_rb r%0d got %h want %h", e.addr, wb_if.rd_data1_o, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_retire_wrap;
    @(negedge clk);
    idle();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    n_checks++;
    if (wb_if.retired_o !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got %h want ffffffff", wb_if.retired_o);
    else n_pass++;
    wb_if.valid_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wb_if.retired_o !== 32'h0) $display("FAIL wrap_zero got %h want 0", wb_if.retired_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_if.retired_o !== 32'h1) $display("FAIL wrap_one got %h want 1", wb_if.retired_o);
    else n_pass++;
    @(negedge clk);
    idle();
    exp_ret = 1;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.reg_write_i = 2'b11; wb_if.reg_write_addr_i = 4'd9;
    wb_if.result_i = 32'h0000_0099; wb_if.pc_set_i = 1'b1;
    wb_if.sp_write_i = 2'b11; wb_if.sp_data_i = 32'h0000_1234;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    idle();
    wb_if.rd_addr1_i = 4'd9; wb_if.rd_addr2_i = 4'd3;
    #1;
    n_checks++;
    if (wb_if.rd_data1_o !== 32'h0) $display("FAIL rstmid_r9 got %h want 0", wb_if.rd_data1_o);
    else n_pass++;
    n_checks++;
    if (wb_if.rd_data2_o !== 32'h0) $display("FAIL rstmid_r3 got %h want 0", wb_if.rd_data2_o);
    else n_pass++;
    n_checks++;
    if (wb_if.sp_o !== 32'h0) $display("FAIL rstmid_usp got %h want 0", wb_if.sp_o);
    else n_pass++;
    n_checks++;
    if (wb_if.pc_set_o !== 1'b0 || wb_if.pc_o !== 32'h0)
      $display("FAIL rstmid_pc got pc %h set %b want 0 0", wb_if.pc_o, wb_if.pc_set_o);
    else n_pass++;
    n_checks++;
    if (wb_if.retired_o !== 32'h0) $display("FAIL rstmid_retired got %h want 0", wb_if.retired_o);
    else n_pass++;
    exp_ret = 0;
  endtask

  task automatic test_halt;
    @(negedge clk);
    idle();
    wb_if.valid_i = 1'b1; wb_if.halt_i = 1'b1; wb_if.reg_write_i = 2'b11;
    wb_if.reg_write_addr_i = 4'd1; wb_if.result_i = 32'h0000_0007;
    @(posedge clk); #1;
    exp_ret++;
    n_checks++;
    if (wb_if.halted_o !== 1'b1) $display("FAIL halt_set got %b want 1", wb_if.halted_o);
    else n_pass++;
    n_checks++;
    if (wb_if.retired_o !== 32'(exp_ret)) $display("FAIL halt_count got %h want %h", wb_if.retired_o, 32'(exp_ret));
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      wb_if.valid_i = 1'b1; wb_if.reg_write_i = 2'b11; wb_if.reg_write_addr_i = 4'd1;
      wb_if.result_i = 32'h0000_0055 + 32'(c); wb_if.pc_set_i = 1'b1; wb_if.rd_addr1_i = 4'd1;
      #1;
      n_checks++;
      if (wb_if.rd_data1_o !== 32'h0000_0007) $display("FAIL halt_nobypass cyc%0d got %h want 7", c, wb_if.rd_data1_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (wb_if.retired_o !== 32'(exp_ret) || wb_if.pc_set_o !== 1'b0)
        $display("FAIL halt_frozen cyc%0d got ret %h set %b want %h 0", c, wb_if.retired_o, wb_if.pc_set_o, 32'(exp_ret));
      else n_pass++;
    end
    @(negedge clk);
    idle();
    wb_if.rd_addr2_i = 4'd1;
    #1;
    n_checks++;
    if (wb_if.rd_data2_o !== 32'h0000_0007) $display("FAIL halt_r1 got %h want 7", wb_if.rd_data2_o);
    else n_pass++;
    n_checks++;
    if (wb_if.halted_o !== 1'b1) $display("FAIL halt_sticky got %b want 1", wb_if.halted_o);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (wb_if.halted_o !== 1'b0 || wb_if.retired_o !== 32'h0)
      $display("FAIL halt_cleared got halted %b ret %h want 0 0", wb_if.halted_o, wb_if.retired_o);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_ret  = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_partial_write();
    test_stall();
    test_sp_redirect();
    test_back_to_back();
    test_retire_wrap();
    test_reset_mid();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
